// File: rtl/lift_scheduler.sv
// lift_scheduler: latches floor calls into a pending mask and serves them in SCAN order,
// stepping one floor per movement tick and holding the door open for a tick-timed dwell.
module lift_scheduler #(
    parameter int FLOORS     = 9,
    parameter int FW         = 4,
    parameter int TICK_DIV   = 50_000_000,
    parameter int DOOR_TICKS = 3
) (
    input  logic              CLOCK_50,
    input  logic              iRST_N,
    input  logic [FLOORS-1:0] iREQ,
    input  logic              iCALL_N,
    output logic [FW-1:0]     oFLOOR,
    output logic [FLOORS-1:0] oPENDING,
    output logic [1:0]        oDIR,
    output logic              oDOOR_OPEN,
    output logic              oMOVING,
    output logic              oEVT
);
    localparam int TW = $clog2(TICK_DIV);
    localparam int DW = $clog2(DOOR_TICKS + 1);

    typedef enum logic [1:0] {IDLE, UP, DOWN, DOOR} state_t;

    state_t            state_q, state_d;
    logic [FW-1:0]     floor_q, floor_d, next_floor, bound;
    logic [FLOORS-1:0] pending_q, pending_d, new_call, clr;
    logic [FLOORS-1:0] cur_oh, next_oh, below_mask, above_mask;
    logic [TW-1:0]     tick_cnt_q, tick_cnt_d;
    logic [DW-1:0]     door_cnt_q, door_cnt_d;
    logic              last_up_q, last_up_d, call_prev_q, evt_q, evt_d;
    logic              tick, above, below;

    always_comb begin
        new_call   = (call_prev_q && !iCALL_N) ? iREQ : '0;
        tick       = tick_cnt_q == TW'(TICK_DIV - 1);
        tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
        cur_oh     = FLOORS'(1) << floor_q;
        below_mask = cur_oh - FLOORS'(1);
        above_mask = ~(below_mask | cur_oh);
        above      = |(pending_q & above_mask);
        below      = |(pending_q & below_mask);
        // Floor saturates at the bound in the direction of travel
        bound      = (state_q == DOWN) ? '0 : FW'(FLOORS - 1);
        next_floor = (floor_q == bound) ? floor_q :
                     (state_q == DOWN) ? floor_q - FW'(1) : floor_q + FW'(1);
        next_oh    = FLOORS'(1) << next_floor;
        state_d    = state_q;
        floor_d    = floor_q;
        last_up_d  = last_up_q;
        door_cnt_d = door_cnt_q;
        clr        = '0;
        case (state_q)
            IDLE: begin
                if (|(pending_q & cur_oh)) begin
                    state_d    = DOOR;
                    door_cnt_d = DW'(DOOR_TICKS);
                    clr        = cur_oh;
                end else if (above && (last_up_q || !below)) begin
                    state_d   = UP;
                    last_up_d = 1'b1;
                end else if (below) begin
                    state_d   = DOWN;
                    last_up_d = 1'b0;
                end
            end
            UP, DOWN: begin
                if (tick) begin
                    floor_d = next_floor;
                    if (|(pending_q & next_oh)) begin
                        state_d    = DOOR;
                        door_cnt_d = DW'(DOOR_TICKS);
                        clr        = next_oh;
                    end else if (next_floor == bound) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                clr = cur_oh;
                // A repeat call at the open floor restarts the dwell, even on a tick
                if (|(new_call & cur_oh)) begin
                    door_cnt_d = DW'(DOOR_TICKS);
                end else if (tick) begin
                    door_cnt_d = door_cnt_q - DW'(1);
                    if (door_cnt_q == DW'(1)) state_d = IDLE;
                end
            end
        endcase
        pending_d = (pending_q | new_call) & ~clr;
        evt_d     = state_d != state_q;
    end

    always_ff @(posedge CLOCK_50) begin
        if (!iRST_N) begin
            state_q     <= IDLE;
            floor_q     <= '0;
            pending_q   <= '0;
            tick_cnt_q  <= '0;
            door_cnt_q  <= '0;
            last_up_q   <= 1'b1;
            call_prev_q <= 1'b1;
            evt_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            floor_q     <= floor_d;
            pending_q   <= pending_d;
            tick_cnt_q  <= tick_cnt_d;
            door_cnt_q  <= door_cnt_d;
            last_up_q   <= last_up_d;
            call_prev_q <= iCALL_N;
            evt_q       <= evt_d;
        end
    end

    assign oFLOOR     = floor_q;
    assign oPENDING   = pending_q;
    assign oDIR       = {state_q == DOWN, state_q == UP};
    assign oDOOR_OPEN = state_q == DOOR;
    assign oMOVING    = (state_q == UP) || (state_q == DOWN);
    assign oEVT       = evt_q;
endmodule

// File: tb/tb_lift_scheduler.sv
// tb_lift_scheduler: directed scenarios with literal expectations plus randomized calls,
// all outputs compared every cycle against a floor/queue-level model of the scheduler.
module tb_lift_scheduler;
    localparam int FLOORS = 9;
    localparam int TICK_DIV = 4;
    localparam int DOOR_TICKS = 2;
    localparam int M_IDLE = 0, M_UP = 1, M_DOWN = 2, M_DOOR = 3;

    logic              clk = 1'b0;
    logic              iRST_N, iCALL_N;
    logic [FLOORS-1:0] iREQ;
    logic [3:0]        o_floor;
    logic [FLOORS-1:0] o_pending;
    logic [1:0]        o_dir;
    logic              o_door, o_moving, o_evt;

    int checks = 0, errors = 0, edges = 0;
    bit check_en = 0;

    int                m_mode = M_IDLE, m_floor = 0, m_tcnt = 0, m_door = 0;
    logic [FLOORS-1:0] m_pend = '0;
    bit                m_prev = 1, m_last_up = 1, m_evt = 0;

    lift_scheduler #(.FLOORS(FLOORS), .FW(4), .TICK_DIV(TICK_DIV), .DOOR_TICKS(DOOR_TICKS)) dut (
        .CLOCK_50(clk), .iRST_N(iRST_N), .iREQ(iREQ), .iCALL_N(iCALL_N),
        .oFLOOR(o_floor), .oPENDING(o_pending), .oDIR(o_dir),
        .oDOOR_OPEN(o_door), .oMOVING(o_moving), .oEVT(o_evt)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic bit calls_above();
        for (int f = m_floor + 1; f < FLOORS; f++) if (m_pend[f]) return 1;
        return 0;
    endfunction

    function automatic bit calls_below();
        for (int f = 0; f < m_floor; f++) if (m_pend[f]) return 1;
        return 0;
    endfunction

    // One clock edge of the lift as described by its rules, in floor numbers
    task automatic model_step();
        logic [FLOORS-1:0] newv;
        int served, prev_mode;
        bit tick;
        if (!iRST_N) begin
            m_mode = M_IDLE; m_floor = 0; m_pend = '0; m_tcnt = 0; m_door = 0;
            m_prev = 1; m_last_up = 1; m_evt = 0; edges = 0;
            return;
        end
        edges++;
        newv = (m_prev && !iCALL_N) ? iREQ : '0;
        tick = m_tcnt == TICK_DIV - 1;
        prev_mode = m_mode;
        served = -1;
        if (m_mode == M_IDLE) begin
            if (m_pend[m_floor]) begin
                m_mode = M_DOOR; m_door = DOOR_TICKS; served = m_floor;
            end else if (calls_above() && (m_last_up || !calls_below())) begin
                m_mode = M_UP; m_last_up = 1;
            end else if (calls_below()) begin
                m_mode = M_DOWN; m_last_up = 0;
            end
        end else if (m_mode == M_DOOR) begin
            served = m_floor;
            if (newv[m_floor]) m_door = DOOR_TICKS;
            else if (tick) begin
                m_door--;
                if (m_door == 0) m_mode = M_IDLE;
            end
        end else if (tick) begin
            m_floor = m_floor + ((m_mode == M_UP) ? 1 : -1);
            if (m_floor > FLOORS - 1) m_floor = FLOORS - 1;
            if (m_floor < 0) m_floor = 0;
            if (m_pend[m_floor]) begin
                m_mode = M_DOOR; m_door = DOOR_TICKS; served = m_floor;
            end else if (m_floor == 0 || m_floor == FLOORS - 1) m_mode = M_IDLE;
        end
        m_pend = m_pend | newv;
        if (served >= 0) m_pend[served] = 1'b0;
        m_evt = m_mode != prev_mode;
        m_prev = iCALL_N;
        m_tcnt = tick ? 0 : m_tcnt + 1;
    endtask

    always @(posedge clk) model_step();

    always @(negedge clk) begin
        if (check_en) begin
            chk("floor", int'(o_floor), m_floor);
            chk("pending", int'(o_pending), int'(m_pend));
            chk("dir", int'(o_dir), (m_mode == M_UP) ? 1 : (m_mode == M_DOWN) ? 2 : 0);
            chk("door_open", int'(o_door), int'(m_mode == M_DOOR));
            chk("moving", int'(o_moving), int'(m_mode == M_UP || m_mode == M_DOWN));
            chk("evt", int'(o_evt), int'(m_evt));
        end
    end

    task automatic wait_edge(input int n);
        int guard = 0;
        while (edges < n && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        if (edges < n) begin
            checks++;
            errors++;
            $display("FAIL wait_edge edges=%0d required=%0d", edges, n);
        end
    endtask

    task automatic pulse(input logic [FLOORS-1:0] r);
        iREQ = r;
        iCALL_N = 1'b0;
        @(negedge clk);
        iCALL_N = 1'b1;
        iREQ = '0;
    endtask

    task automatic chk_zero(string name);
        chk({name, "_floor"}, int'(o_floor), 0);
        chk({name, "_pending"}, int'(o_pending), 0);
        chk({name, "_dir"}, int'(o_dir), 0);
        chk({name, "_door"}, int'(o_door), 0);
        chk({name, "_moving"}, int'(o_moving), 0);
        chk({name, "_evt"}, int'(o_evt), 0);
    endtask

    initial begin
        iRST_N = 1'b0;
        iCALL_N = 1'b1;
        iREQ = '0;
        @(negedge clk);
        check_en = 1;
        repeat (2) @(negedge clk);
        iRST_N = 1'b1;
        wait_edge(3);
        chk_zero("reset");
        wait_edge(100);
        chk_zero("quiet");
        // Single upward call to floor 3
        pulse(9'h008);
        chk("t2_pending", int'(o_pending), 'h008);
        chk("t2_dir_wait", int'(o_dir), 0);
        wait_edge(102);
        chk("t2_dir_up", int'(o_dir), 1);
        chk("t2_evt", int'(o_evt), 1);
        wait_edge(103);
        chk("t2_evt_low", int'(o_evt), 0);
        wait_edge(104);
        chk("t2_floor1", int'(o_floor), 1);
        wait_edge(108);
        chk("t2_floor2", int'(o_floor), 2);
        wait_edge(112);
        chk("t2_floor3", int'(o_floor), 3);
        chk("t2_door", int'(o_door), 1);
        chk("t2_pend_clr", int'(o_pending), 0);
        wait_edge(119);
        chk("t2_dwell", int'(o_door), 1);
        wait_edge(120);
        chk("t2_close", int'(o_door), 0);
        chk("t2_idle_dir", int'(o_dir), 0);
        // SCAN: floors 1 and 6 from floor 3, last direction up
        pulse(9'h042);
        wait_edge(132);
        chk("t3_floor6", int'(o_floor), 6);
        chk("t3_door6", int'(o_door), 1);
        chk("t3_pend1", int'(o_pending), 'h002);
        // Repeat call at floor 6 after one dwell tick restarts the dwell
        wait_edge(136);
        pulse(9'h040);
        chk("t4_pend_keep", int'(o_pending), 'h002);
        wait_edge(140);
        chk("t4_extended", int'(o_door), 1);
        wait_edge(143);
        chk("t4_still_open", int'(o_door), 1);
        wait_edge(144);
        chk("t4_closed", int'(o_door), 0);
        wait_edge(148);
        chk("t3_down5", int'(o_floor), 5);
        chk("t3_dir_down", int'(o_dir), 2);
        wait_edge(164);
        chk("t3_floor1", int'(o_floor), 1);
        chk("t3_door1", int'(o_door), 1);
        // Call for the current floor while idle
        wait_edge(172);
        pulse(9'h002);
        chk("t4b_pend", int'(o_pending), 'h002);
        chk("t4b_no_door", int'(o_door), 0);
        wait_edge(174);
        chk("t4b_door", int'(o_door), 1);
        chk("t4b_floor", int'(o_floor), 1);
        chk("t4b_pend_clr", int'(o_pending), 0);
        // Arrival collision at floor 4 plus a call for floor 0
        wait_edge(180);
        pulse(9'h010);
        wait_edge(191);
        pulse(9'h011);
        chk("t5_floor4", int'(o_floor), 4);
        chk("t5_door", int'(o_door), 1);
        chk("t5_pend", int'(o_pending), 'h001);
        // Reset mid-move toward floor 7
        wait_edge(224);
        pulse(9'h080);
        wait_edge(240);
        chk("t6_floor4", int'(o_floor), 4);
        chk("t6_moving", int'(o_moving), 1);
        iRST_N = 1'b0;
        @(negedge clk);
        chk_zero("t6_reset");
        iRST_N = 1'b1;
        wait_edge(20);
        chk("t6_no_motion", int'(o_floor), 0);
        chk("t6_not_moving", int'(o_moving), 0);
        // Randomized calls, holds and rare resets
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            iRST_N = $urandom_range(0, 599) != 0;
            iCALL_N = $urandom_range(0, 99) >= 15;
            iREQ = ($urandom_range(0, 3) == 0) ? 9'(1 << $urandom_range(0, 8))
                                                : 9'($urandom_range(0, 511) & $urandom_range(0, 511));
        end
        iRST_N = 1'b1;
        iCALL_N = 1'b1;
        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
